timx_apb_master: RTL and testbench
==================================

Name: timx_apb_master

Overview:
- APB initiator that issues single register read/write transfers to the timer's APB slave port (timx_psel/penable/pwrite/paddr/pwdata/prdata).
- Takes one command at a time from a valid/ready command port and sequences correct SETUP/ACCESS phases.
- Honours slave wait states and error, applies a wait-state timeout, and returns one response per command on a valid/ready response port.
- Sits between a configuration sequencer (CPU-side bridge or boot ROM loader) and apoip_timer.

Parameters:
- ADDR_W, 16, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT, 16, maximum ACCESS cycles waiting for pready. 0 disables the timeout.

Ports:
- apb_clk  input  1  bus clock.
- apb_rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_W  byte address.
- cmd_wdata  input  DATA_W  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
- rsp_err  output  2  00 ok, 01 slave error, 10 timeout, 11 unaligned.
- timx_psel  output  1  APB select.
- timx_penable  output  1  APB enable.
- timx_pwrite  output  1  APB direction.
- timx_paddr  output  ADDR_W  APB address.
- timx_pwdata  output  DATA_W  APB write data.
- timx_prdata  input  DATA_W  APB read data.
- timx_pready  input  1  slave ready. Tie to 1 for zero-wait slaves.
- timx_pslverr  input  1  slave error, sampled with pready.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: all outputs 0 except cmd_ready = 1. State = IDLE, timeout counter = 0. Reset asserted in any state aborts at once: psel/penable drop asynchronously, no response is issued, and the command is lost.
- States: IDLE, SETUP, ACCESS, RESP.
- cmd_ready = (state == IDLE). This is combinational from the state only and does not depend on cmd_valid.
- IDLE, on accept:
  - cmd_addr[1:0] != 0: go to RESP with rsp_err = 11 and rsp_rdata = 0. The bus is untouched (psel never rises).
  - Otherwise: register paddr, pwrite and pwdata. pwdata is forced to 0 for reads. Go to SETUP.
- SETUP (exactly 1 cycle): psel = 1, penable = 0. Next state is ACCESS.
- ACCESS: psel = 1, penable = 1. paddr, pwrite and pwdata are held stable from SETUP until the transfer ends.
  - On a clock edge with pready = 1: capture prdata (reads only). rsp_err = 01 if pslverr, else 00. rsp_rdata = 0 on a slave error. Go to RESP.
  - On a clock edge with pready = 0: increment the counter. If TIMEOUT != 0 and this was the TIMEOUT-th waiting ACCESS cycle, go to RESP with rsp_err = 10 and rsp_rdata = 0.
  - pready = 1 on the TIMEOUT-th cycle counts as normal completion, not a timeout.
  - The counter clears on entry to SETUP.
- RESP: psel = penable = 0 and rsp_valid = 1. rsp_rdata and rsp_err stay stable until rsp_ready. On the rsp_ready edge go to IDLE. No new command is accepted in the same cycle.
- Latency:
  - Zero-wait transfer: accept edge N, SETUP N+1, ACCESS N+2, rsp_valid from N+3.
  - Back-to-back throughput: one transfer per 4 cycles with rsp_ready held at 1.
- psel never stays high across two commands, so the slave always sees a fresh SETUP.
- In IDLE, paddr and pwdata keep their last values. pwrite returns to 0.
- Width rules:
  - Counter width is $clog2(TIMEOUT+1), minimum 1 bit, and saturates (no wrap).
  - prdata is captured at full DATA_W. No byte strobes.

Decomposition:
- timx_apb_pkg holds:
  - state encoding (IDLE = 0, SETUP = 1, ACCESS = 2, RESP = 3);
  - rsp_err codes (ERR_OK, ERR_SLV, ERR_TMO, ERR_ALIGN);
  - register offsets used by benches (CR1 0x0000, DIER 0x000C, EGR 0x0014, CCMR1 0x0018, CCER 0x0020, ARR 0x002C, CCR1 0x0034, BDTR 0x0044).
- One sub-module, timx_apb_wait_timer: the saturating ACCESS-cycle counter with clear, enable and an expired output.

Test Plan:
1. Write ARR: cmd write 0x002C / 0x00000008 against apoip_timer, pready = 1 -> psel rises at N+1, penable at N+2, rsp_valid at N+3 with err 00. A following read of 0x002C returns rsp_rdata 0x00000008.
2. Wait states: slave model holds pready low for 3 ACCESS cycles on a read of 0x0034 returning 0x00000004 -> penable high for 4 cycles, paddr stable, rsp_rdata 0x00000004, err 00.
3. Timeout: TIMEOUT = 16, pready stuck at 0 -> exactly 16 ACCESS cycles, then psel drops and rsp_err = 10, rsp_rdata 0. pready = 1 on cycle 16 instead -> err 00.
4. Slave error and unaligned: pslverr = 1 with pready -> err 01, rdata 0. Command addr 0x0022 -> rsp_valid next cycle with err 11 and psel never asserted.
5. Backpressure and stream: program the sequence ARR 8, CCR1 4, DIER 3, CCMR1 0x68, EGR 1, CCER 5, BDTR 0x8C00, CR1 0xA1 with rsp_ready toggling -> each response is held until consumed, cmd_ready stays low in RESP, and the timer starts counting (timx_ch1_out toggles with period 9 clocks).
6. Reset mid-ACCESS: deassert apb_rst_n during penable -> psel/penable go 0 without waiting for a clock edge. After release: cmd_ready = 1, rsp_valid = 0, and a new command completes normally.

Source files
------------

// File: rtl/timx_apb_pkg.sv
// Shared types and constants for the timer APB initiator: FSM encoding,
// response error codes and the timer register map used by benches.
package timx_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_SLV   = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_ALIGN = 2'b11;

  localparam logic [15:0] REG_CR1   = 16'h0000;
  localparam logic [15:0] REG_DIER  = 16'h000C;
  localparam logic [15:0] REG_EGR   = 16'h0014;
  localparam logic [15:0] REG_CCMR1 = 16'h0018;
  localparam logic [15:0] REG_CCER  = 16'h0020;
  localparam logic [15:0] REG_ARR   = 16'h002C;
  localparam logic [15:0] REG_CCR1  = 16'h0034;
  localparam logic [15:0] REG_BDTR  = 16'h0044;

endpackage

// File: rtl/timx_apb_wait_timer.sv
// Saturating count of ACCESS cycles spent waiting on pready; flags the
// cycle that would be the TIMEOUT-th wait (never fires when TIMEOUT == 0).
module timx_apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic apb_clk,
  input  logic apb_rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(TIMEOUT);

  logic [CW-1:0] cnt;
  logic [CW:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt} + (CW+1)'(1);

  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n)            cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && !(&cnt))    cnt <= cnt_inc[CW-1:0];
  end

  // Compare against the post-increment value so the flag is live during the
  // wait cycle that completes the budget, letting the FSM leave on that edge.
  assign expired = (TIMEOUT != 0) && en && (cnt_inc >= LIMIT);

endmodule

// File: rtl/timx_apb_master.sv
// Single-transfer APB initiator for the timer slave port: command in,
// SETUP/ACCESS sequencing with wait-state timeout, one response out.
module timx_apb_master
  import timx_apb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              apb_clk,
  input  logic              apb_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              timx_psel,
  output logic              timx_penable,
  output logic              timx_pwrite,
  output logic [ADDR_W-1:0] timx_paddr,
  output logic [DATA_W-1:0] timx_pwdata,
  input  logic [DATA_W-1:0] timx_prdata,
  input  logic              timx_pready,
  input  logic              timx_pslverr,
  output logic              busy
);

  state_e            state, state_n;
  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        err_q;
  logic              accept, unaligned, wait_en, tmo_expired;

  assign accept    = (state == ST_IDLE) && cmd_valid;
  assign unaligned = |cmd_addr[1:0];
  assign wait_en   = (state == ST_ACCESS) && !timx_pready;

  timx_apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .apb_clk   (apb_clk),
    .apb_rst_n (apb_rst_n),
    .clr       (state == ST_IDLE),
    .en        (wait_en),
    .expired   (tmo_expired)
  );

  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) state <= ST_IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (cmd_valid) state_n = unaligned ? ST_RESP : ST_SETUP;
      ST_SETUP:  state_n = ST_ACCESS;
      ST_ACCESS: if (timx_pready || tmo_expired) state_n = ST_RESP;
      ST_RESP:   if (rsp_ready) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Bus-side and response registers; nothing here changes while in RESP,
  // which keeps the response stable until it is consumed.
  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= ERR_OK;
    end else if (accept) begin
      if (unaligned) begin
        rdata_q <= '0;
        err_q   <= ERR_ALIGN;
      end else begin
        paddr_q  <= cmd_addr;
        pwrite_q <= cmd_write;
        pwdata_q <= cmd_write ? cmd_wdata : '0;
      end
    end else if (state == ST_ACCESS) begin
      if (timx_pready) begin
        rdata_q  <= (pwrite_q || timx_pslverr) ? '0 : timx_prdata;
        err_q    <= timx_pslverr ? ERR_SLV : ERR_OK;
        pwrite_q <= 1'b0;
      end else if (tmo_expired) begin
        rdata_q  <= '0;
        err_q    <= ERR_TMO;
        pwrite_q <= 1'b0;
      end
    end
  end

  // Strobes decode straight from the state register so an async reset
  // drops them without waiting for a clock edge.
  assign cmd_ready    = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign rsp_valid    = (state == ST_RESP);
  assign timx_psel    = (state == ST_SETUP) || (state == ST_ACCESS);
  assign timx_penable = (state == ST_ACCESS);
  assign timx_pwrite  = pwrite_q;
  assign timx_paddr   = paddr_q;
  assign timx_pwdata  = pwdata_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;

endmodule

// File: tb/tb_timx_apb_master.sv
// Scoreboard bench for timx_apb_master: memory-backed APB slave with
// programmable wait/error, reference register model, protocol monitor.
module tb_timx_apb_master;
  import timx_apb_pkg::*;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          apb_clk = 1'b0;
  logic          apb_rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready, rsp_valid, busy;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_err;
  logic          timx_psel, timx_penable, timx_pwrite, timx_pready, timx_pslverr;
  logic [AW-1:0] timx_paddr;
  logic [DW-1:0] timx_pwdata, timx_prdata;

  always #5 apb_clk = ~apb_clk;

  timx_apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .apb_clk(apb_clk), .apb_rst_n(apb_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .timx_psel(timx_psel), .timx_penable(timx_penable), .timx_pwrite(timx_pwrite),
    .timx_paddr(timx_paddr), .timx_pwdata(timx_pwdata), .timx_prdata(timx_prdata),
    .timx_pready(timx_pready), .timx_pslverr(timx_pslverr), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Slave: word memory, pready held low for wait_cfg ACCESS cycles.
  logic [31:0] smem [64] = '{default: 32'h0};
  int   acc_cnt;
  int   wait_cfg = 0;
  logic err_cfg  = 1'b0;

  assign timx_pready  = (acc_cnt >= wait_cfg);
  assign timx_pslverr = err_cfg && timx_pready;
  assign timx_prdata  = smem[timx_paddr[7:2]];

  always @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) acc_cnt <= 0;
    else if (timx_psel && timx_penable && !timx_pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always @(posedge apb_clk)
    if (apb_rst_n && timx_psel && timx_penable && timx_pready && timx_pwrite && !err_cfg)
      smem[timx_paddr[7:2]] <= timx_pwdata;

  // Reference model: expected response and number of penable cycles.
  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [int];
  bit          rr_rand = 1'b0;

  task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d,
                       input int wt, input logic se);
    exp_t e;
    int   n = 0;
    @(negedge apb_clk);
    while (!cmd_ready && n < 200) begin @(negedge apb_clk); n++; end
    if (!cmd_ready) begin chk("cmd_ready_wait", 64'(cmd_ready), 64'd1); return; end
    if (a[1:0] != 2'b00)            e = '{32'h0, ERR_ALIGN, 0};
    else if (TMO != 0 && wt >= TMO) e = '{32'h0, ERR_TMO, TMO};
    else if (se)                    e = '{32'h0, ERR_SLV, wt + 1};
    else if (w) begin
      ref_mem[int'(a)] = d;
      e = '{32'h0, ERR_OK, wt + 1};
    end else
      e = '{ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0, ERR_OK, wt + 1};
    sb.push_back(e);
    wait_cfg  = wt;
    err_cfg   = se;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    @(posedge apb_clk);
    #1 cmd_valid = 1'b0;
  endtask

  initial forever begin
    @(posedge apb_clk);
    #1 rsp_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Response monitor: hold stability while stalled, pop on handshake.
  int   mon_acc = 0;
  bit   held_v  = 1'b0;
  exp_t held;
  always @(negedge apb_clk) begin
    exp_t e;
    if (!apb_rst_n) begin
      mon_acc = 0;
      held_v  = 1'b0;
    end else begin
      if (timx_penable) mon_acc++;
      if (rsp_valid) begin
        if (held_v) begin
          chk("rsp_rdata_hold", 64'(rsp_rdata), 64'(held.rdata));
          chk("rsp_err_hold", 64'(rsp_err), 64'(held.err));
        end
        held   = '{rsp_rdata, rsp_err, 0};
        held_v = 1'b1;
        if (rsp_ready) begin
          if (sb.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
          else begin
            e = sb.pop_front();
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
            chk("access_cycles", 64'(mon_acc), 64'(e.acc));
          end
          mon_acc = 0;
          held_v  = 1'b0;
        end
      end
    end
  end

  // APB protocol monitor.
  logic          prev_psel = 1'b0, prev_pen = 1'b0, lat_w;
  logic [AW-1:0] lat_a;
  logic [DW-1:0] lat_d;
  always @(negedge apb_clk) begin
    if (!apb_rst_n) begin
      prev_psel = 1'b0;
      prev_pen  = 1'b0;
    end else begin
      if (timx_psel && !prev_psel) begin
        chk("setup_penable_low", 64'(timx_penable), 64'd0);
        chk("paddr_aligned", 64'(timx_paddr[1:0]), 64'd0);
        lat_a = timx_paddr; lat_w = timx_pwrite; lat_d = timx_pwdata;
      end
      if (timx_psel && prev_psel) begin
        chk("paddr_stable", 64'(timx_paddr), 64'(lat_a));
        chk("pwrite_stable", 64'(timx_pwrite), 64'(lat_w));
        chk("pwdata_stable", 64'(timx_pwdata), 64'(lat_d));
      end
      if (timx_penable && !prev_pen) chk("setup_before_access", 64'(prev_psel), 64'd1);
      if (timx_psel && !timx_pwrite) chk("read_pwdata_zero", 64'(timx_pwdata), 64'd0);
      if (!timx_psel) chk("idle_pwrite_low", 64'(timx_pwrite), 64'd0);
      if (rsp_valid) chk("cmd_ready_in_resp", 64'(cmd_ready), 64'd0);
      prev_psel = timx_psel;
      prev_pen  = timx_penable;
    end
  end

  logic [15:0] s_addr [8] = '{REG_ARR, REG_CCR1, REG_DIER, REG_CCMR1,
                              REG_EGR, REG_CCER, REG_BDTR, REG_CR1};
  logic [31:0] s_data [8] = '{32'h8, 32'h4, 32'h3, 32'h68, 32'h1, 32'h5, 32'h8C00, 32'hA1};

  initial begin
    int          n;
    logic [15:0] a;
    int          wt;
    repeat (3) @(negedge apb_clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_psel", 64'(timx_psel), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    #2 apb_rst_n = 1'b1;

    // Zero-wait write latency, then read back.
    issue(1'b1, REG_ARR, 32'h8, 0, 1'b0);
    @(negedge apb_clk);
    chk("lat_n1_psel", 64'(timx_psel), 64'd1);
    chk("lat_n1_penable", 64'(timx_penable), 64'd0);
    @(negedge apb_clk);
    chk("lat_n2_penable", 64'(timx_penable), 64'd1);
    chk("lat_n2_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge apb_clk);
    chk("lat_n3_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("lat_n3_psel", 64'(timx_psel), 64'd0);
    issue(1'b0, REG_ARR, 32'h0, 0, 1'b0);

    // Wait states, timeout, completion on last allowed cycle, slave error.
    issue(1'b1, REG_CCR1, 32'h4, 0, 1'b0);
    issue(1'b0, REG_CCR1, 32'h0, 3, 1'b0);
    issue(1'b0, REG_CCR1, 32'h0, 1000, 1'b0);
    issue(1'b0, REG_CCR1, 32'h0, TMO - 1, 1'b0);
    issue(1'b0, REG_CCR1, 32'h0, 1, 1'b1);
    issue(1'b1, REG_CCR1, 32'h77, 0, 1'b1);
    issue(1'b0, REG_CCR1, 32'h0, 0, 1'b0);

    // Unaligned command never touches the bus.
    issue(1'b1, 16'h0022, 32'hDEAD, 0, 1'b0);
    @(negedge apb_clk);
    chk("unaligned_rsp_next", 64'(rsp_valid), 64'd1);
    chk("unaligned_no_psel", 64'(timx_psel), 64'd0);

    // Timer programming stream under backpressure, then read back.
    rr_rand = 1'b1;
    for (int i = 0; i < 8; i++) issue(1'b1, s_addr[i], s_data[i], i % 3, 1'b0);
    for (int i = 0; i < 8; i++) issue(1'b0, s_addr[i], 32'h0, 0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      a = {8'h00, 6'($urandom), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      case ($urandom_range(0, 9))
        0:       wt = TMO + int'($urandom_range(0, 4));
        1:       wt = TMO - 1;
        default: wt = int'($urandom_range(0, 3));
      endcase
      issue(1'($urandom), a, $urandom, wt, $urandom_range(0, 9) == 0);
    end

    // Drain outstanding responses before the reset test.
    n = 0;
    while ((sb.size() != 0 || busy) && n < 5000) begin @(negedge apb_clk); n++; end
    chk("drain_before_reset", 64'(sb.size()), 64'd0);

    // Async reset in the middle of ACCESS.
    rr_rand = 1'b0;
    issue(1'b0, REG_CR1, 32'h0, 1000, 1'b0);
    repeat (3) @(negedge apb_clk);
    chk("pre_reset_penable", 64'(timx_penable), 64'd1);
    #2 apb_rst_n = 1'b0;
    #1;
    chk("reset_psel_async", 64'(timx_psel), 64'd0);
    chk("reset_penable_async", 64'(timx_penable), 64'd0);
    sb.delete();
    @(negedge apb_clk);
    #2 apb_rst_n = 1'b1;
    @(negedge apb_clk);
    chk("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("post_reset_rsp_valid", 64'(rsp_valid), 64'd0);
    issue(1'b0, REG_CR1, 32'h0, 1, 1'b0);

    n = 0;
    while ((sb.size() != 0 || busy) && n < 5000) begin @(negedge apb_clk); n++; end
    chk("final_drain", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
